// File: rtl/stencil_pkg.sv
// -----------------------------------------------------------------------------
// stencil_pkg
// Shared constants and helpers for the 3x3 streaming stencil convolution.
//   KSIZE      : window edge length (3)
//   NTAPS      : taps per window (9), tap k = KSIZE*row + col, row/col 0 oldest
//   acc_width  : accumulator width needed to sum NTAPS full-width products
//   tap_arr_t  : generic per-tap value container (up to 64 bits per tap)
// -----------------------------------------------------------------------------
package stencil_pkg;

    localparam int KSIZE     = 3;
    localparam int NTAPS     = KSIZE * KSIZE;
    localparam int TAP_W_MAX = 64;

    // Nine 2*W-bit products fit in 2*W+4 bits (9 < 16).
    function automatic int acc_width(input int data_w);
        return 2 * data_w + 4;
    endfunction

    typedef logic [TAP_W_MAX-1:0] tap_arr_t [NTAPS];

endpackage

// File: rtl/stencil_line_buf.sv
// -----------------------------------------------------------------------------
// stencil_line_buf
// Fixed-length pixel delay line: dout_o presents the pixel written DEPTH
// enabled cycles earlier. Implemented as a circular buffer so only the write
// pointer moves; storage itself is never reset.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (pointer only)
//   en_i   : advance the line by one pixel
//   din_i  : pixel entering the line
//   dout_o : pixel leaving the line (valid before the enabling edge)
// -----------------------------------------------------------------------------
module stencil_line_buf
    import stencil_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;

    // Read-before-write at the same slot gives exactly DEPTH cycles of delay.
    assign dout_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/stencil_conv_stream.sv
// -----------------------------------------------------------------------------
// stencil_conv_stream
// Streaming 3x3 convolution over raster-ordered frames of IMG_W x IMG_H
// unsigned pixels. Only fully interior windows (x>=2, y>=2) are emitted.
// Two-cycle pipeline: p0 window register, p1 products, p2 adder + output.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   in_valid  / in_ready  / in_data  : pixel input handshake
//   mode      : 0 unit-weight sum, 1 weighted sum (sampled at frame start)
//   coef      : 9 unsigned weights, tap k at [k*DATA_W +: DATA_W]
//   out_valid / out_ready / out_data : result output handshake
//   out_last  : result belongs to the last window of the frame
// -----------------------------------------------------------------------------
module stencil_conv_stream
    import stencil_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 64,
    parameter int ACC_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    mode,
    input  logic [NTAPS*DATA_W-1:0] coef,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last
);

    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = acc_width(DATA_W);

    function automatic logic [DATA_W-1:0] shift_trunc(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] s;
        s = a >> ACC_SHIFT;
        return s[DATA_W-1:0];
    endfunction

    logic                    adv;
    logic                    accept;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic                    x_end, y_end;
    logic                    frame_start;
    logic                    win_ok;

    logic                    mode_q;
    logic [NTAPS*DATA_W-1:0] coef_q;

    logic [DATA_W-1:0]       row1_pix;
    logic [DATA_W-1:0]       row0_pix;
    logic [DATA_W-1:0]       col_in [KSIZE];

    logic [DATA_W-1:0]       win_p0_q [KSIZE][KSIZE];
    logic                    vld_p0_q, last_p0_q;
    logic [PROD_W-1:0]       prod_p1_d [NTAPS];
    logic [PROD_W-1:0]       prod_p1_q [NTAPS];
    logic                    vld_p1_q, last_p1_q;
    logic [ACC_W-1:0]        acc_p2_d;
    logic                    out_valid_q, out_last_q;
    logic [DATA_W-1:0]       out_data_q;

    // The whole pipeline moves only when the output slot is free or draining.
    assign in_ready    = !(out_valid_q && !out_ready);
    assign adv         = in_ready;
    assign accept      = in_valid && in_ready;

    assign x_end       = (x_q == XW'(IMG_W - 1));
    assign y_end       = (y_q == YW'(IMG_H - 1));
    assign frame_start = accept && (x_q == '0) && (y_q == '0);
    // Interior-only gating also keeps stale line-buffer rows from a previous
    // frame (or from before a reset) away from the output.
    assign win_ok      = (x_q >= XW'(2)) && (y_q >= YW'(2));

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    stencil_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line_y1 (
        .clk    (clk),
        .rst_n  (reset),
        .en_i   (accept),
        .din_i  (in_data),
        .dout_o (row1_pix)
    );

    stencil_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line_y2 (
        .clk    (clk),
        .rst_n  (reset),
        .en_i   (accept),
        .din_i  (row1_pix),
        .dout_o (row0_pix)
    );

    assign col_in[0] = row0_pix;
    assign col_in[1] = row1_pix;
    assign col_in[2] = in_data;

    // ---- stage p1: per-tap products from the registered window ----
    always_comb begin
        prod_p1_d = '{default: '0};
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                prod_p1_d[r*KSIZE + c] = mode_q
                    ? PROD_W'(win_p0_q[r][c]) * PROD_W'(coef_q[(r*KSIZE + c)*DATA_W +: DATA_W])
                    : PROD_W'(win_p0_q[r][c]);
            end
        end
    end

    // ---- stage p2: adder tree over the nine products ----
    always_comb begin
        acc_p2_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc_p2_d = acc_p2_d + ACC_W'(prod_p1_q[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q         <= '0;
            y_q         <= '0;
            vld_p0_q    <= 1'b0;
            last_p0_q   <= 1'b0;
            vld_p1_q    <= 1'b0;
            last_p1_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (adv) begin
                vld_p0_q    <= accept && win_ok;
                last_p0_q   <= accept && x_end && y_end;
                vld_p1_q    <= vld_p0_q;
                last_p1_q   <= last_p0_q;
                out_valid_q <= vld_p1_q;
                out_last_q  <= last_p1_q;
                if (vld_p1_q) begin
                    out_data_q <= shift_trunc(acc_p2_d);
                end
            end
        end
    end

    // ---- stage p0: frame config latch and 3x3 window shift ----
    always_ff @(posedge clk) begin
        if (frame_start) begin
            mode_q <= mode;
            coef_q <= coef;
        end
        if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
                win_p0_q[r][0] <= win_p0_q[r][1];
                win_p0_q[r][1] <= win_p0_q[r][2];
                win_p0_q[r][2] <= col_in[r];
            end
        end
        if (adv) begin
            prod_p1_q <= prod_p1_d;
        end
    end

endmodule

// File: tb/tb_stencil_conv_stream.sv
module tb_stencil_conv_stream;
    import stencil_pkg::*;

    localparam int DATA_W = 16;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int SHIFT1 = 3;

    typedef struct {
        longint unsigned acc;
        bit              last;
        longint          cyc;
        bit              lat;
    } exp_t;

    logic                    clk;
    logic                    reset_n;
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    mode;
    logic [NTAPS*DATA_W-1:0] coef;
    logic                    out_ready;
    logic                    ir [2];
    logic                    ov [2];
    logic [DATA_W-1:0]       od [2];
    logic                    ol [2];

    exp_t   q [2][$];
    int     n_pass = 0;
    int     n_total = 0;
    longint cyc = 0;
    int     stall_left = 0;
    bit     bp_rand = 0;
    bit     lat_mode = 0;

    // reference model state
    int              mx, my;
    logic [15:0]     img [IMG_H][IMG_W];
    bit              fmode;
    logic [15:0]     fcoef [NTAPS];

    // monitor state
    bit              held_v [2];
    logic [15:0]     held_d [2];
    bit              held_l [2];

    stencil_conv_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ACC_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .mode(mode), .coef(coef), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_last(ol[0])
    );

    stencil_conv_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ACC_SHIFT(SHIFT1)) dut1 (
        .clk(clk), .reset(reset_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .mode(mode), .coef(coef), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_last(ol[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic void model_reset();
        mx = 0;
        my = 0;
    endfunction

    // Spec-level model: keep the frame as an image, sum the 3x3 neighbourhood
    // ending at the newest pixel whenever it is an interior position.
    function automatic void model_accept(input logic [15:0] p);
        tap_arr_t        win;
        longint unsigned acc;
        exp_t            e;
        if (mx == 0 && my == 0) begin
            fmode = mode;
            for (int k = 0; k < NTAPS; k++) fcoef[k] = coef[k*DATA_W +: DATA_W];
        end
        img[my][mx] = p;
        if (mx >= 2 && my >= 2) begin
            acc = 0;
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++)
                    win[3*dy + dx] = 64'(img[my-2+dy][mx-2+dx]);
            for (int k = 0; k < NTAPS; k++)
                acc += win[k] * (fmode ? longint'(fcoef[k]) : 64'd1);
            e.acc  = acc;
            e.last = (mx == IMG_W-1) && (my == IMG_H-1);
            e.cyc  = cyc;
            e.lat  = lat_mode;
            q[0].push_back(e);
            q[1].push_back(e);
        end
        mx++;
        if (mx == IMG_W) begin
            mx = 0;
            my = (my == IMG_H-1) ? 0 : my + 1;
        end
    endfunction

    task automatic randomize_cfg();
        mode = 1'($urandom);
        for (int k = 0; k < NTAPS; k++) coef[k*DATA_W +: DATA_W] = 16'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_pix(input logic [15:0] p, input int gap);
        bit rdy;
        int waited;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_data  = p;
        rdy = 0;
        waited = 0;
        while (!rdy && waited < 300) begin
            @(negedge clk);
            rdy = ir[0];
            @(posedge clk);
            #1;
            waited++;
        end
        if (rdy) model_accept(p);
        else chk(1'b0, "accept_timeout", waited, 300);
    endtask

    task automatic send_frame(input int kind, input logic [15:0] cval, input int npix,
                              input bit rgap, input bit scramble, input int stall_at);
        logic [15:0] p;
        for (int i = 0; i < npix; i++) begin
            case (kind)
                0:       p = 16'(i + 1);
                1:       p = cval;
                default: p = 16'($urandom);
            endcase
            send_pix(p, rgap ? int'($urandom_range(0, 2)) : 0);
            if (i == stall_at) stall_left = 5;
            if (scramble) randomize_cfg();
        end
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while ((q[0].size() != 0 || q[1].size() != 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(q[0].size() == 0 && q[1].size() == 0, "drain_all_results", q[0].size() + q[1].size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk(ov[d] == 1'b0, {tag, "_out_valid"}, ov[d], 0);
            chk(od[d] == '0,   {tag, "_out_data"},  od[d], 0);
            chk(ol[d] == 1'b0, {tag, "_out_last"},  ol[d], 0);
            chk(ir[d] == 1'b1, {tag, "_in_ready"},  ir[d], 1);
        end
    endtask

    task automatic enter_reset();
        reset_n = 1'b0;
        q[0].delete();
        q[1].delete();
        model_reset();
        stall_left = 0;
    endtask

    // out_ready driver: forced stalls, random backpressure, or always ready.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (bp_rand) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor: samples at negedge, a transfer occurs at the next posedge.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] want;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                held_v[d] = 0;
            end else begin
                chk(ir[d] == !(ov[d] && !out_ready), "in_ready_rule", ir[d], !(ov[d] && !out_ready));
                if (held_v[d]) begin
                    chk(ov[d] == 1'b1,      "stall_hold_valid", ov[d], 1);
                    chk(od[d] == held_d[d], "stall_hold_data",  od[d], held_d[d]);
                    chk(ol[d] == held_l[d], "stall_hold_last",  ol[d], held_l[d]);
                end
                held_v[d] = ov[d] && !out_ready;
                held_d[d] = od[d];
                held_l[d] = ol[d];
                if (ov[d] && out_ready) begin
                    if (q[d].size() == 0) begin
                        chk(1'b0, d == 0 ? "unexpected_result0" : "unexpected_result1", od[d], 0);
                    end else begin
                        e = q[d].pop_front();
                        want = 16'(e.acc >> (d == 0 ? 0 : SHIFT1));
                        chk(od[d] == want, d == 0 ? "out_data_shift0" : "out_data_shift3", od[d], want);
                        chk(ol[d] == e.last, "out_last", ol[d], e.last);
                        if (e.lat) chk(cyc - e.cyc == 2, "latency", cyc - e.cyc, 2);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got %0d cycles, required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        mode     = 1'b0;
        coef     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed frames, streamed back to back, always ready
        lat_mode = 1;
        mode = 1'b0;
        send_frame(0, 16'd0, IMG_W*IMG_H, 0, 0, -1);          // 54 63 90 99
        mode = 1'b1;
        coef = '0;
        coef[4*DATA_W +: DATA_W] = 16'd1;
        send_frame(0, 16'd0, IMG_W*IMG_H, 0, 0, -1);          // 6 7 10 11
        mode = 1'b0;
        send_frame(1, 16'hFFFF, IMG_W*IMG_H, 0, 0, -1);       // 0xFFF7
        send_frame(1, 16'd8, IMG_W*IMG_H, 0, 0, -1);          // 72, 9 after >>3
        drain();
        lat_mode = 0;

        // Five-cycle stall while results are in flight
        send_frame(0, 16'd0, IMG_W*IMG_H, 0, 0, 11);
        drain();

        // Asynchronous reset while a result is held under backpressure
        stall_left = 1000;
        send_frame(0, 16'd0, 12, 0, 0, -1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(ov[0] == 1'b1, "stalled_result_pending", ov[0], 1);
        enter_reset();
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset after 7 pixels, then a fresh frame
        send_frame(0, 16'd0, 7, 0, 0, -1);
        in_valid = 1'b0;
        enter_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mode = 1'b0;
        send_frame(0, 16'd0, IMG_W*IMG_H, 0, 0, -1);
        drain();

        // Random frames, random gaps, random backpressure, config scrambled mid-frame
        bp_rand = 1;
        for (int f = 0; f < 8; f++) begin
            randomize_cfg();
            send_frame(2, 16'd0, IMG_W*IMG_H, 1, 1, -1);
        end
        in_valid = 1'b0;
        bp_rand = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stencil_conv_stream.md
STENCIL_CONV_STREAM -- requirements
Module: stencil_conv_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning pixel, coefficient and output width in bits.
REQ-002 SHALL have parameter IMG_W, default 64, meaning pixels per row (min 3).
REQ-003 SHALL have parameter IMG_H, default 64, meaning rows per frame (min 3).
REQ-004 SHALL have parameter ACC_SHIFT, default 0, meaning right-shift applied to accumulator before output truncation.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  input pixel valid.
REQ-008 SHALL have port in_ready  output  1  block accepts pixel this cycle.
REQ-009 SHALL have port in_data  input  DATA_W  pixel, raster order, unsigned.
REQ-010 SHALL have port mode  input  1  0 = unit-weight 3x3 sum, 1 = weighted 3x3 sum.
REQ-011 SHALL have port coef  input  9*DATA_W  unsigned weights, tap k at bits [k*DATA_W +: DATA_W], k = 3*row + col, k=0 oldest row/oldest column.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_data  output  DATA_W  convolution result.
REQ-015 SHALL have port out_last  output  1  result is final window of frame.

Function
REQ-016 Pixel transfer SHALL occur iff in_valid && in_ready; result transfer iff out_valid && out_ready.
REQ-017 in_ready SHALL equal !(out_valid && !out_ready); whole pipeline stalls together, no bubbles inserted on stall.
REQ-018 Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) SHALL advance per accepted pixel; x wraps to 0 incrementing y; at x=IMG_W-1,y=IMG_H-1 both wrap to 0 (next frame).
REQ-019 Two line delays of IMG_W pixels SHALL supply rows y-1, y-2; three 3-deep column shift registers SHALL form the 3x3 window, shifting only on accepted pixels.
REQ-020 A window SHALL be emitted only for accepted pixels with x>=2 and y>=2: exactly (IMG_W-2)*(IMG_H-2) results per frame, no row-wrap windows.
REQ-021 Latency SHALL be 2 cycles: pixel accepted at edge t yields out_valid after edge t+2 absent stalls (stage 1 window+products, stage 2 adder tree).
REQ-022 mode and coef SHALL be sampled when pixel (x=0,y=0) is accepted and held for the whole frame.
REQ-023 mode 0: acc = sum of 9 taps; mode 1: acc = sum of tap_k*coef_k; products 2*DATA_W bits, acc 2*DATA_W+4 bits, no overflow in acc.
REQ-024 out_data SHALL be bits [DATA_W-1:0] of (acc >> ACC_SHIFT) — modulo wrap, no saturation.
REQ-025 out_last SHALL be 1 only with the result of window x=IMG_W-1, y=IMG_H-1; out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-026 Consecutive frames SHALL stream back-to-back with no idle cycle; line-buffer contents from prior frame SHALL never reach an output (gated by REQ-020).

Reset
REQ-027 On reset low: x, y, pipeline valid bits, out_valid, out_data, out_last SHALL clear to 0 immediately; in_ready SHALL read 1.
REQ-028 Reset mid-frame SHALL discard in-flight results; the first pixel after release is (x=0,y=0) of a new frame.
REQ-029 Line-buffer storage SHALL NOT require reset.

Structure
REQ-030 Shared package stencil_pkg SHALL hold KSIZE=3, NTAPS=9, accumulator-width function, and the tap-array typedef.
REQ-031 Line delay SHALL be sub-module stencil_line_buf (DATA_W, DEPTH=IMG_W, enable input), instantiated twice.

Verification
REQ-032 IMG_W=4,IMG_H=4, mode 0, pixels 1..16 -> results 54, 63, 90, 99; out_last only with 99.
REQ-033 Same frame, mode 1, coef tap 4 = 1 others 0 -> results 6, 7, 10, 11.
REQ-034 DATA_W=16, all pixels 0xFFFF, mode 0 -> every result 0xFFF7 (wrap).
REQ-035 ACC_SHIFT=3, all pixels 8, mode 0 -> every result 9; with out_ready=1, out_valid 2 cycles after pixel (2,2) accepted.
REQ-036 out_ready held low 5 cycles mid-frame -> in_ready low same cycles, out_data stable, result sequence identical to REQ-032.
REQ-037 Reset after 7 pixels, then fresh 1..16 frame -> no output before 11th new pixel; results as REQ-032.
